// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (IF) and data access (DM).
// Define ARB_PERF_CNT_EN to add grant and conflict-cycle performance counters.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_BURST = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic              stall_IF,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              stall_MEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_conflict_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_DM_BURST);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant_if;
  logic                w_grant_dm;
  logic                w_done_if;
  logic                w_done_dm;
  logic                w_if_starved;

  logic [3:0]          r_burst_cnt;
  logic                r_if_flushed;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [3:0]          r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [31:0]         r_if_rdata;
  logic [31:0]         r_dm_rdata;
  logic                r_if_ready;
  logic                r_dm_ready;

  // IF wins over a pending DM request once DM has taken MAX_DM_BURST grants in a row
  assign w_if_starved = if_req && (r_burst_cnt == BURST_LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_dm  = 1'b0;
    w_done_if   = 1'b0;
    w_done_dm   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dm_req && !w_if_starved) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = ST_DM_BUSY;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY: begin
        if (mem_ack) begin
          w_done_if   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DM_BUSY: begin
        if (mem_ack) begin
          w_done_dm   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-side request registers and per-port response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_cnt  <= 4'd0;
      r_if_flushed <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_if_rdata   <= 32'd0;
      r_dm_rdata   <= 32'd0;
      r_if_ready   <= 1'b0;
      r_dm_ready   <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;

      if (w_grant_dm) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dm_we;
        r_mem_be    <= dm_be;
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
        if (if_req) begin
          r_burst_cnt <= (r_burst_cnt >= BURST_LIMIT) ? BURST_LIMIT : r_burst_cnt + 4'd1;
        end else begin
          r_burst_cnt <= 4'd0;
        end
      end

      if (w_grant_if) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_be     <= 4'd0;
        r_mem_addr   <= if_addr;
        r_mem_wdata  <= 32'd0;
        r_burst_cnt  <= 4'd0;
        r_if_flushed <= 1'b0;
      end

      // A fetch dropped at any point while outstanding is a flush; remember it until completion
      if ((r_state == ST_IF_BUSY) && !if_req) begin
        r_if_flushed <= 1'b1;
      end

      if (w_done_if) begin
        r_mem_req <= 1'b0;
        if (if_req && !r_if_flushed) begin
          r_if_rdata <= mem_rdata;
          r_if_ready <= 1'b1;
        end
      end

      if (w_done_dm) begin
        r_mem_req  <= 1'b0;
        r_dm_ready <= 1'b1;
        if (!r_mem_we) begin
          r_dm_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign stall_IF  = if_req && !r_if_ready;
  assign stall_MEM = dm_req && !r_dm_ready;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_if_grants;
  logic [31:0] r_perf_dm_grants;
  logic [31:0] r_perf_conflict;
  logic        w_conflict;

  assign w_conflict = stall_IF && stall_MEM;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_if_grants <= 32'd0;
      r_perf_dm_grants <= 32'd0;
      r_perf_conflict  <= 32'd0;
    end else begin
      if (w_grant_if) r_perf_if_grants <= r_perf_if_grants + 32'd1;
      if (w_grant_dm) r_perf_dm_grants <= r_perf_dm_grants + 32'd1;
      if (w_conflict) r_perf_conflict  <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_if_grants       = r_perf_if_grants;
  assign perf_dm_grants       = r_perf_dm_grants;
  assign perf_conflict_cycles = r_perf_conflict;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and responses are queued at stimulus time
// and popped by a negedge monitor; a latency-programmable memory model answers mem_req.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_dm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic        is_dm;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_r = 1'b0, if_drop = 1'b0;
  logic        dm_req_r = 1'b0, dm_drop = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = 4'd0;
  logic [31:0] dm_addr = 32'd0, dm_wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  wire         if_req, dm_req;
  wire  [31:0] if_rdata, dm_rdata, mem_wdata, mem_addr;
  wire         if_ready, dm_ready, stall_IF, stall_MEM, mem_req, mem_we;
  wire  [3:0]  mem_be;
`ifdef ARB_PERF_CNT_EN
  wire  [31:0] perf_if_grants, perf_dm_grants, perf_conflict_cycles;
  logic [31:0] m_if_g = 0, m_dm_g = 0, m_conf = 0;
  logic        p_rst = 1'b0, p_conf = 1'b0;
`endif

  // Requesters optionally withdraw in their own ready cycle so it is not taken as a new request
  assign if_req = if_req_r && !(if_drop && if_ready);
  assign dm_req = dm_req_r && !(dm_drop && dm_ready);

  int          n_checks = 0, n_errors = 0;
  txn_t        gnt_q[$];
  rsp_t        rsp_q[$];
  txn_t        mon_t;
  rsp_t        mon_r;
  logic [68:0] hold_v = '0;
  logic        prev_req = 1'b0;
  logic        mon_en = 1'b0;
  int          mem_lat = 1, mem_cnt = 0, late_tok = 0, late_seen = 0;
  logic [31:0] mem_xor = 32'd0;
  logic [31:0] exp_if_rdata = 32'd0, exp_dm_rdata = 32'd0;

  mem_port_arbiter #(.MAX_DM_BURST(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .stall_IF(stall_IF),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall_MEM(stall_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic exp_if(input logic [31:0] a, input logic responds);
    txn_t t;
    rsp_t r;
    t.is_dm = 1'b0; t.we = 1'b0; t.be = 4'd0; t.addr = a; t.wdata = 32'd0;
    gnt_q.push_back(t);
    if (responds) begin
      exp_if_rdata = a ^ mem_xor;
      r.is_dm = 1'b0; r.rdata = exp_if_rdata;
      rsp_q.push_back(r);
    end
  endtask

  task automatic exp_dm(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input logic responds);
    txn_t t;
    rsp_t r;
    t.is_dm = 1'b1; t.we = we; t.be = be; t.addr = a; t.wdata = wd;
    gnt_q.push_back(t);
    if (responds) begin
      if (!we) exp_dm_rdata = a ^ mem_xor;
      r.is_dm = 1'b1; r.rdata = exp_dm_rdata;
      rsp_q.push_back(r);
    end
  endtask

  task automatic drive_dm(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    dm_we = we; dm_be = be; dm_addr = a; dm_wdata = wd; dm_req_r = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while ((gnt_q.size() != 0 || rsp_q.size() != 0) && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 96'(gnt_q.size() == 0 && rsp_q.size() == 0), 96'(1));
  endtask

  // Memory model: ack after mem_lat cycles of mem_req (0 = never); late_tok forces one stray ack
  always @(negedge clk) begin
    if (late_tok != late_seen) begin
      late_seen = late_tok;
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
    end else if (mem_req) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ mem_xor;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFF0000;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_cnt   = 0;
      mem_rdata = 32'hFFFF0000;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
`ifdef ARB_PERF_CNT_EN
    if (p_rst) begin
      m_if_g = 0; m_dm_g = 0; m_conf = 0;
    end else if (p_conf) begin
      m_conf = m_conf + 1;
    end
    if (mem_req && !prev_req) begin
      if (mem_be != 4'd0) m_dm_g = m_dm_g + 1;
      else                m_if_g = m_if_g + 1;
    end
    if (mon_en) begin
      chk("perf_if_grants", 96'(perf_if_grants), 96'(m_if_g));
      chk("perf_dm_grants", 96'(perf_dm_grants), 96'(m_dm_g));
      chk("perf_conflict", 96'(perf_conflict_cycles), 96'(m_conf));
    end
    p_rst  = rst;
    p_conf = stall_IF && stall_MEM;
`endif
    if (mon_en) begin
      chk("stall_IF", 96'(stall_IF), 96'(if_req && !if_ready));
      chk("stall_MEM", 96'(stall_MEM), 96'(dm_req && !dm_ready));
      if (mem_req && !prev_req) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_grant", 96'(mem_addr), 96'(0));
        end else begin
          mon_t = gnt_q.pop_front();
          chk("grant_we", 96'(mem_we), 96'(mon_t.we));
          chk("grant_be", 96'(mem_be), 96'(mon_t.be));
          chk("grant_addr", 96'(mem_addr), 96'(mon_t.addr));
          if (mon_t.is_dm) chk("grant_wdata", 96'(mem_wdata), 96'(mon_t.wdata));
        end
        hold_v = {mem_we, mem_be, mem_addr, mem_wdata};
      end else if (mem_req) begin
        chk("mem_hold", 96'({mem_we, mem_be, mem_addr, mem_wdata}), 96'(hold_v));
      end
      if (if_ready) begin
        if (rsp_q.size() == 0 || rsp_q[0].is_dm) begin
          chk("unexpected_if_ready", 96'(1), 96'(0));
        end else begin
          mon_r = rsp_q.pop_front();
          chk("if_rdata", 96'(if_rdata), 96'(mon_r.rdata));
        end
      end
      if (dm_ready) begin
        if (rsp_q.size() == 0 || !rsp_q[0].is_dm) begin
          chk("unexpected_dm_ready", 96'(1), 96'(0));
        end else begin
          mon_r = rsp_q.pop_front();
          chk("dm_rdata", 96'(dm_rdata), 96'(mon_r.rdata));
        end
      end
    end
    prev_req = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 96'(mem_req), 96'(0));
    chk("rst_mem_fields", 96'({mem_we, mem_be, mem_addr, mem_wdata}), 96'(0));
    chk("rst_rdata", 96'({if_rdata, dm_rdata}), 96'(0));
    chk("rst_ready", 96'({if_ready, dm_ready}), 96'(0));
    @(posedge clk); #1 mon_en = 1'b1;

    // IF-only read with a 1-cycle memory
    mem_lat = 1; mem_xor = 32'h00000017;
    exp_if(32'h4, 1'b1);
    if_addr = 32'h4; if_req_r = 1'b1; if_drop = 1'b1;
    @(negedge clk);
    chk("t1_stall_c0", 96'(stall_IF), 96'(1));
    chk("t1_memreq_c0", 96'(mem_req), 96'(0));
    @(negedge clk);
    chk("t1_mem_c1", 96'({mem_req, mem_we, mem_addr}), 96'({1'b1, 1'b0, 32'h4}));
    chk("t1_stall_c1", 96'(stall_IF), 96'(1));
    @(negedge clk);
    chk("t1_ready_c2", 96'({if_ready, if_rdata}), 96'({1'b1, 32'h00000013}));
    @(posedge clk); #1 if_req_r = 1'b0;
    wait_drain(10, "t1_drain");

    // DM write, 3-cycle memory
    mem_lat = 3; mem_xor = 32'h0F0F0F0F;
    @(posedge clk); #1;
    exp_dm(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1);
    drive_dm(1'b1, 4'hF, 32'h100, 32'hDEADBEEF); dm_drop = 1'b1;
    wait_drain(20, "t2_drain");
    @(posedge clk); #1 dm_req_r = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_dm_rdata_kept", 96'(dm_rdata), 96'(0));

    // DM read then partial write: the write must leave the read data in place
    mem_lat = 2; mem_xor = 32'hCAFEF20D;
    @(posedge clk); #1;
    exp_dm(1'b0, 4'hF, 32'h200, 32'h0, 1'b1);
    drive_dm(1'b0, 4'hF, 32'h200, 32'h0);
    wait_drain(20, "t3_read_drain");
    @(posedge clk); #1 dm_req_r = 1'b0;
    @(posedge clk); #1;
    mem_lat = 1;
    exp_dm(1'b1, 4'b0011, 32'h204, 32'h01020304, 1'b1);
    drive_dm(1'b1, 4'b0011, 32'h204, 32'h01020304);
    wait_drain(20, "t3_write_drain");
    @(posedge clk); #1 dm_req_r = 1'b0;
    @(negedge clk);
    chk("t3_dm_rdata_after_write", 96'(dm_rdata), 96'(32'hCAFEF00D));

    // Simultaneous requests: DM first, IF granted in the dm_ready cycle
    mem_lat = 2; mem_xor = 32'h11110000;
    @(posedge clk); #1;
    exp_dm(1'b0, 4'hF, 32'h300, 32'h0, 1'b1);
    exp_if(32'h40, 1'b1);
    drive_dm(1'b0, 4'hF, 32'h300, 32'h0);
    if_addr = 32'h40; if_req_r = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      chk("t4_stall_IF_held", 96'(stall_IF), 96'(1));
      if (dm_ready) break;
    end
    chk("t4_dm_ready_seen", 96'(dm_ready), 96'(1));
    @(posedge clk); #1 dm_req_r = 1'b0;
    @(negedge clk);
    chk("t4_if_grant_next", 96'({mem_req, mem_addr}), 96'({1'b1, 32'h40}));
    wait_drain(20, "t4_drain");
    @(posedge clk); #1 if_req_r = 1'b0;

    // Starvation guard with MAX_DM_BURST=2: both requesters held continuously
    mem_lat = 1; mem_xor = 32'h5A5A0000;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2 || k == 5) exp_if(32'h44, 1'b1);
      else                  exp_dm(1'b0, 4'hF, 32'h600, 32'h0, 1'b1);
    end
    if_drop = 1'b0; dm_drop = 1'b0;
    drive_dm(1'b0, 4'hF, 32'h600, 32'h0);
    if_addr = 32'h44; if_req_r = 1'b1;
    for (int k = 0; k < 60 && gnt_q.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    chk("t5_all_granted", 96'(gnt_q.size()), 96'(0));
    @(posedge clk); #1 dm_req_r = 1'b0; if_drop = 1'b1; dm_drop = 1'b1;
    wait_drain(20, "t5_drain");
    @(posedge clk); #1 if_req_r = 1'b0;

    // IF flush: fetch dropped the cycle after its grant
    mem_lat = 3; mem_xor = 32'h80 ^ 32'h12345678;
    @(posedge clk); #1;
    exp_if(32'h80, 1'b0);
    exp_if_rdata = 32'h44 ^ 32'h5A5A0000;
    if_addr = 32'h80; if_req_r = 1'b1;
    @(posedge clk); #1 if_req_r = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_if_rdata_kept", 96'(if_rdata), 96'(exp_if_rdata));
    chk("t6_mem_idle", 96'(mem_req), 96'(0));
    chk("t6_grant_seen", 96'(gnt_q.size()), 96'(0));
    mem_lat = 1;
    @(posedge clk); #1;
    exp_dm(1'b0, 4'hF, 32'h700, 32'h0, 1'b1);
    drive_dm(1'b0, 4'hF, 32'h700, 32'h0);
    wait_drain(20, "t6_recover_drain");
    @(posedge clk); #1 dm_req_r = 1'b0;

    // Reset while DM_BUSY, followed by a stray ack
    mem_lat = 0;
    @(posedge clk); #1;
    exp_dm(1'b0, 4'hF, 32'h500, 32'h0, 1'b0);
    drive_dm(1'b0, 4'hF, 32'h500, 32'h0);
    repeat (3) @(negedge clk);
    chk("t7_busy", 96'(mem_req), 96'(1));
    @(posedge clk); #1 rst = 1'b1; dm_req_r = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    exp_dm_rdata = 32'd0; exp_if_rdata = 32'd0;
    @(negedge clk);
    chk("t7_mem_req_dropped", 96'(mem_req), 96'(0));
    chk("t7_no_dm_ready", 96'(dm_ready), 96'(0));
    chk("t7_rdata_cleared", 96'({if_rdata, dm_rdata}), 96'(0));
`ifdef ARB_PERF_CNT_EN
    chk("t7_perf_zero", 96'({perf_if_grants, perf_dm_grants, perf_conflict_cycles}), 96'(0));
`endif
    late_tok = late_tok + 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t7_late_ack_ignored", 96'({mem_req, dm_ready, dm_rdata}), 96'(0));
    end

    // Normal operation after reset
    mem_lat = 2; mem_xor = 32'h00A0B0C0;
    @(posedge clk); #1;
    exp_if(32'h8, 1'b1);
    if_addr = 32'h8; if_req_r = 1'b1; if_drop = 1'b1;
    wait_drain(20, "t8_drain");
    @(posedge clk); #1 if_req_r = 1'b0;
    repeat (3) @(negedge clk);
    chk("t8_if_rdata", 96'(if_rdata), 96'(32'h00A0B0C8));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
